// File: rtl/wall_follow_pkg.sv
// Shared types, widths and the setpoint clamp for the wall-follow setpoint path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wall_follow_pkg;

  localparam int IR_W  = 16;
  localparam int RPM_W = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FOLLOW = 2'd1,
    TURN   = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Pivot side: the inner wheel of a turn runs backward.
  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_t;

  // Saturate a signed intermediate into [0, hi]; never wraps.
  function automatic logic [RPM_W-1:0] clamp_rpm(input logic signed [RPM_W+1:0] v,
                                                 input logic [RPM_W-1:0] hi);
    logic signed [RPM_W+1:0] hi_s;
    hi_s = $signed({2'b00, hi});
    if (v[RPM_W+1]) begin
      return '0;
    end else if (v > hi_s) begin
      return hi;
    end else begin
      return v[RPM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/wall_setpoint_gen_slew_limiter.sv
// Per-wheel slew limiter: ramps setpoint toward target, flips direction only at zero.
// Latency: one cycle after tick_i.
// Backpressure: none; updates on every tick_i.
module slew_limiter
  import wall_follow_pkg::*;
#(
  parameter int RAMP_STEP = 20,
  parameter int MAX_RPM   = 250
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             tick_i,
  input  logic [RPM_W-1:0] tgt_mag_i,
  input  logic             tgt_dir_i,
  output logic [RPM_W-1:0] sp_o,
  output logic             dir_o
);

  localparam logic [RPM_W-1:0] STEP  = RPM_W'(RAMP_STEP);
  localparam logic [RPM_W-1:0] MAX_U = RPM_W'(MAX_RPM);

  logic [RPM_W-1:0] sp_q, sp_d, eff;
  logic             dir_q, dir_d;

  // A direction change first drives the wheel to zero; the flip tick itself holds zero.
  always_comb begin
    dir_d = dir_q;
    eff   = clamp_rpm({2'b00, tgt_mag_i}, MAX_U);
    if (tgt_dir_i != dir_q) begin
      eff = '0;
      if (sp_q == '0) begin
        dir_d = tgt_dir_i;
      end
    end
    if (eff > sp_q) begin
      sp_d = ((eff - sp_q) > STEP) ? sp_q + STEP : eff;
    end else begin
      sp_d = ((sp_q - eff) > STEP) ? sp_q - STEP : eff;
    end
  end

  // Setpoint and direction registers, advanced only on the stage-3 strobe.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      sp_q  <= '0;
      dir_q <= 1'b0;
    end else if (tick_i) begin
      sp_q  <= sp_d;
      dir_q <= dir_d;
    end
  end

  assign sp_o  = sp_q;
  assign dir_o = dir_q;

endmodule

// File: rtl/wall_setpoint_gen.sv
// Wall-follow setpoint generator: IR filter -> FSM/targets -> per-wheel slew, once per tick.
// Latency: setpoint_valid_out pulses 3 cycles after the internal control tick.
// Backpressure: none; consumers must take the setpoints on each valid pulse.
module wall_setpoint_gen
  import wall_follow_pkg::*;
#(
  parameter int UPDATE_DIV  = 1_000_000,
  parameter int BASE_RPM    = 120,
  parameter int MAX_RPM     = 250,
  parameter int STEER_SHIFT = 4,
  parameter int TURN_RPM    = 80,
  parameter int TURN_TICKS  = 50,
  parameter int RAMP_STEP   = 20
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             enable_switch,
  input  logic             forward_ir,
  input  logic [IR_W-1:0]  left_ir,
  input  logic [IR_W-1:0]  right_ir,
  output logic [RPM_W-1:0] rpm_setpoint_l_out,
  output logic [RPM_W-1:0] rpm_setpoint_r_out,
  output logic             left_motor_en,
  output logic             right_motor_en,
  output logic             left_motor_direction,
  output logic             right_motor_direction,
  output logic             setpoint_valid_out,
  output logic [1:0]       state_out
);

  localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int AVG_W = IR_W + 2;
  localparam int ERR_W = IR_W + 3;
  localparam int SW    = RPM_W + 2;
  localparam int TC_W  = $clog2(TURN_TICKS + 1);

  localparam logic signed [ERR_W-1:0] STEER_MAX = ERR_W'(BASE_RPM);
  localparam logic signed [SW-1:0]    BASE_S    = SW'(BASE_RPM);
  localparam logic [RPM_W-1:0]        MAX_U     = RPM_W'(MAX_RPM);
  localparam logic [RPM_W-1:0]        TURN_U    = RPM_W'(TURN_RPM);
  localparam logic [TC_W-1:0]         TT        = TC_W'(TURN_TICKS);

  logic                    en_s1_q, en_s2_q, fwd_s1_q, fwd_s2_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    tick, s1_vld_q, s2_vld_q, vld_q, en_q;
  logic signed [AVG_W-1:0] avg_l_q, avg_r_q, dl, dr;
  logic signed [ERR_W-1:0] err, steer_raw, steer;
  logic signed [SW-1:0]    steer_x;
  logic [RPM_W-1:0]        fol_l, fol_r, tgt_l_q, tgt_r_q, sp_l, sp_r;
  logic                    tdir_l_q, tdir_r_q, dir_l, dir_r, sp_zero;
  side_t                   side_q, side_new;
  state_t                  state_q;
  logic [TC_W-1:0]         tcnt_q;

  // Two-flop synchronizers for the asynchronous switch and obstacle inputs.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      {en_s2_q, en_s1_q}   <= 2'b00;
      {fwd_s2_q, fwd_s1_q} <= 2'b00;
    end else begin
      {en_s2_q, en_s1_q}   <= {en_s1_q, enable_switch};
      {fwd_s2_q, fwd_s1_q} <= {fwd_s1_q, forward_ir};
    end
  end

  assign tick = (cnt_q == CNT_W'(UPDATE_DIV - 1));

  // Control-tick divider.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

  assign dl = $signed({2'b00, left_ir})  - avg_l_q;
  assign dr = $signed({2'b00, right_ir}) - avg_r_q;

  // Stage 1: quarter-weight IIR on each IR reading, sampled on the tick cycle.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      avg_l_q  <= '0;
      avg_r_q  <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= tick;
      if (tick) begin
        avg_l_q <= avg_l_q + (dl >>> 2);
        avg_r_q <= avg_r_q + (dr >>> 2);
      end
    end
  end

  assign err       = {avg_r_q[AVG_W-1], avg_r_q} - {avg_l_q[AVG_W-1], avg_l_q};
  assign steer_raw = err >>> STEER_SHIFT;

  // Steering correction limited so that neither wheel target can exceed twice cruise.
  always_comb begin
    steer = steer_raw;
    if (steer_raw > STEER_MAX) begin
      steer = STEER_MAX;
    end else if (steer_raw < -STEER_MAX) begin
      steer = -STEER_MAX;
    end
  end

  assign steer_x  = {{(SW-ERR_W){steer[ERR_W-1]}}, steer};
  assign fol_l    = clamp_rpm(BASE_S - steer_x, MAX_U);
  assign fol_r    = clamp_rpm(BASE_S + steer_x, MAX_U);
  assign side_new = (avg_r_q < avg_l_q) ? SIDE_R : SIDE_L;
  assign sp_zero  = (sp_l == '0) && (sp_r == '0);

  // Stage 2: wall-follow FSM; targets registered from the state being entered.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= IDLE;
      side_q   <= SIDE_L;
      tcnt_q   <= '0;
      tgt_l_q  <= '0;
      tgt_r_q  <= '0;
      tdir_l_q <= 1'b0;
      tdir_r_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        tgt_l_q  <= '0;
        tgt_r_q  <= '0;
        tdir_l_q <= 1'b0;
        tdir_r_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (en_s2_q) begin
              state_q <= FOLLOW;
              tgt_l_q <= fol_l;
              tgt_r_q <= fol_r;
            end
          end
          FOLLOW: begin
            if (!en_s2_q) begin
              state_q <= STOP;
            end else if (fwd_s2_q) begin
              state_q  <= TURN;
              tcnt_q   <= TT;
              side_q   <= side_new;
              tgt_l_q  <= TURN_U;
              tgt_r_q  <= TURN_U;
              tdir_l_q <= (side_new == SIDE_L);
              tdir_r_q <= (side_new == SIDE_R);
            end else begin
              tgt_l_q <= fol_l;
              tgt_r_q <= fol_r;
            end
          end
          TURN: begin
            if (!en_s2_q) begin
              state_q <= STOP;
            end else if ((tcnt_q == '0) && !fwd_s2_q) begin
              state_q <= FOLLOW;
              tgt_l_q <= fol_l;
              tgt_r_q <= fol_r;
            end else begin
              tcnt_q   <= (tcnt_q == '0) ? TT : tcnt_q - 1'b1;
              tgt_l_q  <= TURN_U;
              tgt_r_q  <= TURN_U;
              tdir_l_q <= (side_q == SIDE_L);
              tdir_r_q <= (side_q == SIDE_R);
            end
          end
          STOP: begin
            if (sp_zero) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  slew_limiter #(.RAMP_STEP(RAMP_STEP), .MAX_RPM(MAX_RPM)) u_slew_l (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .tick_i    (s2_vld_q),
    .tgt_mag_i (tgt_l_q),
    .tgt_dir_i (tdir_l_q),
    .sp_o      (sp_l),
    .dir_o     (dir_l)
  );

  slew_limiter #(.RAMP_STEP(RAMP_STEP), .MAX_RPM(MAX_RPM)) u_slew_r (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .tick_i    (s2_vld_q),
    .tgt_mag_i (tgt_r_q),
    .tgt_dir_i (tdir_r_q),
    .sp_o      (sp_r),
    .dir_o     (dir_r)
  );

  // Stage 3: motor enables registered alongside the setpoints, plus the update strobe.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      en_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        en_q <= (state_q != IDLE);
      end
    end
  end

  assign rpm_setpoint_l_out    = sp_l;
  assign rpm_setpoint_r_out    = sp_r;
  assign left_motor_en         = en_q;
  assign right_motor_en        = en_q;
  assign left_motor_direction  = dir_l;
  assign right_motor_direction = dir_r;
  assign setpoint_valid_out    = vld_q;
  assign state_out             = state_q;

endmodule

// File: tb/tb_wall_setpoint_gen.sv
// Bench for wall_setpoint_gen: per-tick reference model feeds an expected-result queue.
// Latency: expects each valid pulse 12 cycles after reset release, then every UPDATE_DIV.
// Backpressure: n/a.
module tb_wall_setpoint_gen;

  localparam int DIV = 10;

  typedef struct {
    int sp_l;
    int sp_r;
    int en;
    int dl;
    int dr;
    int st;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        enable_switch, forward_ir;
  logic [15:0] left_ir, right_ir;
  logic [25:0] rpm_setpoint_l_out, rpm_setpoint_r_out;
  logic        left_motor_en, right_motor_en;
  logic        left_motor_direction, right_motor_direction;
  logic        setpoint_valid_out;
  logic [1:0]  state_out;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_vld = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   lat;
  bit   first_v = 1'b0;
  exp_t exp_q[$];
  exp_t e_m;

  int m_avg_l, m_avg_r, m_state, m_ctr, m_side, m_sp_l, m_sp_r, m_dl, m_dr;

  wall_setpoint_gen #(.UPDATE_DIV(DIV)) dut (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .enable_switch         (enable_switch),
    .forward_ir            (forward_ir),
    .left_ir               (left_ir),
    .right_ir              (right_ir),
    .rpm_setpoint_l_out    (rpm_setpoint_l_out),
    .rpm_setpoint_r_out    (rpm_setpoint_r_out),
    .left_motor_en         (left_motor_en),
    .right_motor_en        (right_motor_en),
    .left_motor_direction  (left_motor_direction),
    .right_motor_direction (right_motor_direction),
    .setpoint_valid_out    (setpoint_valid_out),
    .state_out             (state_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_avg_l = 0; m_avg_r = 0; m_state = 0; m_ctr = 0; m_side = 0;
    m_sp_l = 0; m_sp_r = 0; m_dl = 0; m_dr = 0;
  endtask

  task automatic slew(input int sp, input int d, input int t, input int td,
                      output int nsp, output int nd);
    int eff;
    nd  = d;
    eff = t;
    if (td != d) begin
      eff = 0;
      if (sp == 0) nd = td;
    end
    if (eff > sp) nsp = (eff - sp > 20) ? sp + 20 : eff;
    else          nsp = (sp - eff > 20) ? sp - 20 : eff;
  endtask

  // One control tick of the whole specified behaviour, collapsed to a single step.
  task automatic model_tick(input int en, input int fwd, input int l, input int r);
    int err, steer, fl, fr, tl, tr, tdl, tdr, nside, nsp, nd;
    exp_t e;
    m_avg_l = m_avg_l + ((l - m_avg_l) >>> 2);
    m_avg_r = m_avg_r + ((r - m_avg_r) >>> 2);
    err   = m_avg_r - m_avg_l;
    steer = err >>> 4;
    if (steer > 120)  steer = 120;
    if (steer < -120) steer = -120;
    fl = 120 - steer; fr = 120 + steer;
    if (fl > 250) fl = 250;
    if (fr > 250) fr = 250;
    nside = (m_avg_r < m_avg_l) ? 1 : 0;
    case (m_state)
      0: if (en != 0) m_state = 1;
      1: begin
        if (en == 0) m_state = 3;
        else if (fwd != 0) begin m_state = 2; m_ctr = 50; m_side = nside; end
      end
      2: begin
        if (en == 0) m_state = 3;
        else if (m_ctr == 0) begin
          if (fwd != 0) m_ctr = 50; else m_state = 1;
        end else m_ctr--;
      end
      default: if (m_sp_l == 0 && m_sp_r == 0) m_state = 0;
    endcase
    tl = 0; tr = 0; tdl = 0; tdr = 0;
    if (m_state == 1) begin tl = fl; tr = fr; end
    else if (m_state == 2) begin
      tl = 80; tr = 80;
      tdl = (m_side == 0) ? 1 : 0;
      tdr = (m_side == 1) ? 1 : 0;
    end
    slew(m_sp_l, m_dl, tl, tdl, nsp, nd); m_sp_l = nsp; m_dl = nd;
    slew(m_sp_r, m_dr, tr, tdr, nsp, nd); m_sp_r = nsp; m_dr = nd;
    e.sp_l = m_sp_l; e.sp_r = m_sp_r; e.dl = m_dl; e.dr = m_dr;
    e.en = (m_state != 0) ? 1 : 0;
    e.st = m_state;
    exp_q.push_back(e);
  endtask

  // Drive one tick's worth of inputs, predict, then wait (bounded) for the update.
  task automatic step(input bit en, input bit fwd, input int l, input int r);
    int start, k;
    enable_switch = en; forward_ir = fwd;
    left_ir = 16'(l); right_ir = 16'(r);
    model_tick(int'(en), int'(fwd), l, r);
    start = n_vld;
    k = 0;
    while (n_vld == start && k < 4 * DIV) begin
      @(posedge clk_in);
      k++;
    end
    check_val("vld_seen", int'(n_vld != start), 1);
  endtask

  task automatic do_release();
    @(negedge clk_in);
    model_reset();
    exp_q.delete();
    last_cyc = cyc;
    first_v  = 1'b1;
    reset_in = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_sp_l"}, int'(rpm_setpoint_l_out), 0);
    check_val({tag, "_sp_r"}, int'(rpm_setpoint_r_out), 0);
    check_val({tag, "_en"}, int'({left_motor_en, right_motor_en}), 0);
    check_val({tag, "_dir"}, int'({left_motor_direction, right_motor_direction}), 0);
    check_val({tag, "_vld"}, int'(setpoint_valid_out), 0);
    check_val({tag, "_state"}, int'(state_out), 0);
  endtask

  // Scoreboard: every valid pulse pops one prediction and checks timing and outputs.
  always @(negedge clk_in) begin
    if (reset_in && setpoint_valid_out) begin
      lat = cyc - last_cyc;
      if (first_v) check_val("vld_latency", lat, 12);
      else         check_val("vld_gap", lat, DIV);
      first_v  = 1'b0;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_val("vld_unexpected", exp_q.size(), 1);
      end else begin
        e_m = exp_q.pop_front();
        check_val("sp_l", int'(rpm_setpoint_l_out), e_m.sp_l);
        check_val("sp_r", int'(rpm_setpoint_r_out), e_m.sp_r);
        check_val("en_l", int'(left_motor_en), e_m.en);
        check_val("en_r", int'(right_motor_en), e_m.en);
        check_val("dir_l", int'(left_motor_direction), e_m.dl);
        check_val("dir_r", int'(right_motor_direction), e_m.dr);
        check_val("state", int'(state_out), e_m.st);
      end
      n_vld++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    enable_switch = 1'b0; forward_ir = 1'b0;
    left_ir = '0; right_ir = '0;
    reset_in = 1'b1;
    #3 reset_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all_zero("rst");

    // Reset asserted mid-ramp clears everything without waiting for a clock edge.
    do_release();
    repeat (3) step(1'b1, 1'b0, 1000, 1000);
    check_val("pre_rst_sp_l", int'(rpm_setpoint_l_out), 60);
    @(negedge clk_in);
    #2 reset_in = 1'b0;
    #1 check_all_zero("rst_mid");

    // Straight cruise ramp to 120/120.
    do_release();
    repeat (12) step(1'b1, 1'b0, 1000, 1000);
    check_val("cruise_l", int'(rpm_setpoint_l_out), 120);
    check_val("cruise_r", int'(rpm_setpoint_r_out), 120);

    // Right wall closer: steer 62 once the filter settles.
    repeat (40) step(1'b1, 1'b0, 1000, 2000);
    check_val("steer_l", int'(rpm_setpoint_l_out), 58);
    check_val("steer_r", int'(rpm_setpoint_r_out), 182);

    // Obstacle: pivot left, then back to FOLLOW after the minimum turn.
    step(1'b1, 1'b1, 1000, 2000);
    check_val("turn_entry", int'(state_out), 2);
    repeat (50) step(1'b1, 1'b0, 1000, 2000);
    check_val("turn_hold", int'(state_out), 2);
    check_val("turn_sp_l", int'(rpm_setpoint_l_out), 80);
    check_val("turn_dir_l", int'(left_motor_direction), 1);
    check_val("turn_sp_r", int'(rpm_setpoint_r_out), 80);
    check_val("turn_dir_r", int'(right_motor_direction), 0);
    step(1'b1, 1'b0, 1000, 2000);
    check_val("turn_exit", int'(state_out), 1);

    // Obstacle persisting keeps the FSM in TURN.
    repeat (60) step(1'b1, 1'b1, 1000, 2000);
    check_val("turn_persist", int'(state_out), 2);

    // Disable during TURN: ramp down, re-enable mid-ramp, then IDLE and FOLLOW.
    step(1'b0, 1'b1, 1000, 2000);
    check_val("stop_entry", int'(state_out), 3);
    check_val("stop_sp_l", int'(rpm_setpoint_l_out), 60);
    step(1'b0, 1'b0, 1000, 2000);
    repeat (3) step(1'b1, 1'b0, 1000, 2000);
    check_val("idle_state", int'(state_out), 0);
    check_val("idle_en", int'({left_motor_en, right_motor_en}), 0);
    check_val("idle_dir", int'({left_motor_direction, right_motor_direction}), 0);
    check_val("idle_sp", int'(rpm_setpoint_l_out) + int'(rpm_setpoint_r_out), 0);
    step(1'b1, 1'b0, 1000, 2000);
    check_val("refollow", int'(state_out), 1);

    repeat (2) @(negedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
